led_blink_driver: RTL and testbench
===================================

LED_BLINK_DRIVER -- requirements
Module: led_blink_driver

Interface
REQ-001 Parameter ON_TICKS, default 12500000, SHALL set the LED-on phase length in clk cycles (minimum 1).
REQ-002 Parameter OFF_TICKS, default 12500000, SHALL set the LED-off phase length in clk cycles (minimum 1).
REQ-003 Parameter COUNT_W, default 4, SHALL set the width of the blink-count request.
REQ-004 Port clk, input, 1, SHALL be the single system clock; all state changes occur on its rising edge.
REQ-005 Port i_Reset, input, 1, SHALL be an asynchronous, active-high reset.
REQ-006 Port i_Start, input, 1, SHALL be a synchronous request strobe, sampled every cycle.
REQ-007 Port i_Count, input, COUNT_W, SHALL give the number of blinks N and is sampled only when i_Start=1.
REQ-008 Port o_LED, output, 1, SHALL be the registered LED drive (1 = lit).
REQ-009 Port o_Busy, output, 1, SHALL be high while a blink sequence is running.
REQ-010 Port o_Done, output, 1, SHALL be a one-cycle completion pulse.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, ON and OFF.
REQ-012 IDLE with i_Start=1 and N>0 at edge t: the block SHALL latch N, enter ON, and drive o_LED=1 and o_Busy=1 from cycle t+1.
REQ-013 ON SHALL last exactly ON_TICKS cycles with o_LED=1, then the FSM SHALL enter OFF.
REQ-014 OFF SHALL last exactly OFF_TICKS cycles with o_LED=0, then decrement the remaining count; if the count is nonzero the FSM SHALL re-enter ON, otherwise it SHALL enter IDLE.
REQ-015 A sequence of N blinks SHALL hold o_Busy high for exactly N*(ON_TICKS+OFF_TICKS) cycles.
REQ-016 o_Done SHALL pulse for one cycle, in the first IDLE cycle after the final OFF phase.
REQ-017 IDLE with i_Start=1 and N=0: the block SHALL produce no blink, keep o_Busy=0, and pulse o_Done at t+1.
REQ-018 i_Start while o_Busy=1 SHALL follow the rule in Configuration.
REQ-019 i_Start in the same cycle as the o_Done pulse SHALL be accepted as a fresh IDLE request.
REQ-020 The phase counter SHALL be $clog2(max(ON_TICKS,OFF_TICKS)+1) bits wide, SHALL reset to 0 on every phase entry and SHALL never wrap.
REQ-021 The remaining-count register SHALL be COUNT_W bits and SHALL never underflow.
REQ-022 The maximum N, 2^COUNT_W-1, SHALL be fully supported.

Reset
REQ-023 While i_Reset=1 the block SHALL be asynchronously forced to IDLE with o_LED=0, o_Busy=0, o_Done=0 and all counters at 0.
REQ-024 Reset asserted mid-sequence SHALL abort the sequence with no o_Done pulse.
REQ-025 After reset deasserts, the first i_Start SHALL be honoured on the next rising edge.

Configuration
REQ-026 With BLINK_RETRIGGER_EN defined, i_Start while busy SHALL abort the current sequence with no o_Done pulse.
- The new N is latched.
- The FSM enters ON at the next cycle with the phase counter cleared.
- If N=0, the FSM goes to IDLE, pulses o_Done and drives o_LED=0.
REQ-027 Without BLINK_RETRIGGER_EN, i_Start while busy SHALL be ignored and the current sequence SHALL be unaffected.

Structure
REQ-028 Package blink_pkg SHALL hold the state encoding (IDLE=2'd0, ON=2'd1, OFF=2'd2) and the phase-counter width function.
REQ-029 Phase timing SHALL live in one sub-module, blink_timer.
- It has a load input and a terminal-count output.
- It is instantiated once.
- It is reloaded with ON_TICKS or OFF_TICKS on each phase entry.

Verification
All scenarios use ON_TICKS=3, OFF_TICKS=2, COUNT_W=4.
REQ-030 Start with N=2 at cycle 0 -> o_LED high on cycles 1-3 and 6-8, low elsewhere; o_Busy high on cycles 1-10; o_Done high on cycle 11 only.
REQ-031 Start with N=0 -> o_LED and o_Busy stay 0; o_Done high on cycle 1 only.
REQ-032 Start with N=1 at cycle 0, then i_Start with N=3 at cycle 2:
- Without the macro: o_Done at cycle 6, no further blinks.
- With BLINK_RETRIGGER_EN: three blinks starting at cycle 3, o_Done at cycle 18.
REQ-033 Start with N=15 -> exactly 15 rising edges on o_LED and o_Busy high for 75 cycles, then one o_Done pulse.
REQ-034 Assert i_Reset at cycle 4 of an N=3 sequence -> o_LED, o_Busy and o_Done are 0 immediately with no clock edge needed; no o_Done pulse follows; a start after release runs a full, normal sequence.
REQ-035 Start asserted in the o_Done cycle of an N=1 sequence with N=1 -> o_LED high on the following cycle; back-to-back sequences run with no gap.

Source files
------------

// File: rtl/blink_pkg.sv
// blink_pkg: state encoding and phase-counter width helper for led_blink_driver
package blink_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, OFF = 2'd2} state_t;
  function automatic int phase_w(input int a, input int b);
    return $clog2((a > b ? a : b) + 1);
  endfunction
endpackage

// File: rtl/led_blink_driver_if.sv
// led_blink_driver_if: start/count request and LED/busy/done status bundle
interface led_blink_driver_if #(parameter int COUNT_W = 4);
  logic i_Start;
  logic [COUNT_W-1:0] i_Count;
  logic o_LED;
  logic o_Busy;
  logic o_Done;
  modport master (output i_Start, i_Count, input o_LED, o_Busy, o_Done);
  modport slave (input i_Start, i_Count, output o_LED, o_Busy, o_Done);
endinterface

// File: rtl/blink_timer.sv
// blink_timer: phase timer, cleared and given a new length on load; tc marks the last cycle
module blink_timer #(parameter int W = 4) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  logic [W-1:0] ticks,
  output logic tc
);
  logic [W-1:0] cnt, lim;
  assign tc = cnt == lim - W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      lim <= '0;
    end else if (load) begin
      cnt <= '0;
      lim <= ticks;
    end else if (en && !tc) cnt <= cnt + W'(1);
endmodule

// File: rtl/led_blink_driver.sv
// led_blink_driver: blinks an LED N times; define BLINK_RETRIGGER_EN to let i_Start restart a running sequence
module led_blink_driver
  import blink_pkg::*;
#(
  parameter int ON_TICKS  = 12500000,
  parameter int OFF_TICKS = 12500000,
  parameter int COUNT_W   = 4
) (
  input logic clk,
  input logic i_Reset,
  led_blink_driver_if.slave bus
);
  localparam int W = phase_w(ON_TICKS, OFF_TICKS);
  state_t state;
  logic [COUNT_W-1:0] rem;
  logic led, busy, done, start_ok, load, tc;
  logic [W-1:0] ticks;
  always_comb begin
`ifdef BLINK_RETRIGGER_EN
    start_ok = bus.i_Start;
`else
    start_ok = bus.i_Start && state == IDLE;
`endif
    load = start_ok || (state != IDLE && tc);
    ticks = (state == ON && tc) ? W'(OFF_TICKS) : W'(ON_TICKS);
  end
  blink_timer #(.W(W)) u_timer (
    .clk(clk), .rst(i_Reset), .load(load), .en(busy), .ticks(ticks), .tc(tc)
  );
  always_ff @(posedge clk or posedge i_Reset)
    if (i_Reset) begin
      state <= IDLE;
      rem <= '0;
      led <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_ok) begin
        state <= bus.i_Count != '0 ? ON : IDLE;
        rem <= bus.i_Count;
        led <= bus.i_Count != '0;
        busy <= bus.i_Count != '0;
        done <= bus.i_Count == '0;
      end else if (state == ON && tc) begin
        state <= OFF;
        led <= 1'b0;
      end else if (state == OFF && tc) begin
        rem <= rem - COUNT_W'(1);
        state <= rem == COUNT_W'(1) ? IDLE : ON;
        led <= rem != COUNT_W'(1);
        busy <= rem != COUNT_W'(1);
        done <= rem == COUNT_W'(1);
      end
    end
  assign bus.o_LED = led;
  assign bus.o_Busy = busy;
  assign bus.o_Done = done;
endmodule

// File: tb/tb_led_blink_driver.sv
// tb_led_blink_driver: directed scenarios queue per-cycle expected {led,busy,done}; a negedge monitor checks them
module tb_led_blink_driver;
  logic clk = 1'b0;
  logic i_Reset;
  always #5 clk = ~clk;
  led_blink_driver_if #(.COUNT_W(4)) bus ();
  led_blink_driver #(.ON_TICKS(3), .OFF_TICKS(2), .COUNT_W(4)) dut (
    .clk(clk), .i_Reset(i_Reset), .bus(bus)
  );
  typedef struct {int cyc; int rel; logic [2:0] v; string tag;} exp_t;
  exp_t q[$];
  exp_t e;
  logic [2:0] plan [0:99];
  logic [2:0] got;
  int cyc = 0, c0 = 0, tests = 0, fails = 0;
  string tag;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      got = {bus.o_LED, bus.o_Busy, bus.o_Done};
      tests++;
      if (got !== e.v || e.cyc != cyc) begin
        fails++;
        $display("FAIL %s cycle %0d: led/busy/done got %b expected %b", e.tag, e.rel, got, e.v);
      end
    end
  initial begin
    #100000;
    fails++;
    $display("FAIL timeout: wait expired at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  task automatic clr(input string t);
    tag = t;
    foreach (plan[i]) plan[i] = '0;
  endtask
  task automatic mark(input int b, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) plan[c][b] = 1'b1;
  endtask
  task automatic go(input int len);
    exp_t x;
    c0 = cyc;
    for (int j = 0; j <= len; j++) begin
      x.cyc = c0 + j;
      x.rel = j;
      x.v = plan[j];
      x.tag = tag;
      q.push_back(x);
    end
  endtask
  task automatic at(input int r);
    while (cyc - c0 < r) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic pulse(input logic [3:0] n);
    bus.i_Start = 1'b1;
    bus.i_Count = n;
    @(posedge clk);
    #1;
    bus.i_Start = 1'b0;
  endtask
  initial begin
    bus.i_Start = 1'b0;
    bus.i_Count = '0;
    i_Reset = 1'b1;
    @(posedge clk);
    #1;
    clr("reset"); go(3); at(2); i_Reset = 1'b0; at(4);
    clr("n2");
    mark(2, 1, 3); mark(2, 6, 8); mark(1, 1, 10); mark(0, 11, 11);
    go(13); pulse(4'd2); at(14);
    clr("n0"); mark(0, 1, 1); go(4); pulse(4'd0); at(5);
    clr("start_while_busy");
`ifdef BLINK_RETRIGGER_EN
    mark(2, 1, 5); mark(2, 8, 10); mark(2, 13, 15); mark(1, 1, 17); mark(0, 18, 18);
`else
    mark(2, 1, 3); mark(1, 1, 5); mark(0, 6, 6);
`endif
    go(20); pulse(4'd1); at(2); pulse(4'd3); at(21);
    clr("n15");
    for (int k = 0; k < 15; k++) mark(2, 1 + 5 * k, 3 + 5 * k);
    mark(1, 1, 75); mark(0, 76, 76);
    go(79); pulse(4'd15); at(80);
    clr("reset_mid");
    mark(2, 1, 3); mark(1, 1, 3);
    go(20); pulse(4'd3); at(4); i_Reset = 1'b1;
    #1;
    tests++;
    if ({bus.o_LED, bus.o_Busy, bus.o_Done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_async: led/busy/done got %b expected 000", {bus.o_LED, bus.o_Busy, bus.o_Done});
    end
    at(6); i_Reset = 1'b0; at(21);
    clr("after_reset");
    mark(2, 1, 3); mark(1, 1, 5); mark(0, 6, 6);
    go(7); pulse(4'd1); at(8);
    clr("back_to_back");
    mark(2, 1, 3); mark(2, 7, 9); mark(1, 1, 5); mark(1, 7, 11); mark(0, 6, 6); mark(0, 12, 12);
    go(13); pulse(4'd1); at(6); pulse(4'd1); at(14);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
